// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, FSM encoding and stall decode for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int REG_BUS       = 32;
    localparam int INST_ADDR_BUS = 32;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    localparam logic [INST_ADDR_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic {
        PIPE_RUN  = 1'b0,
        PIPE_WAIT = 1'b1
    } pipe_state_t;

    // Deepest requesting stage wins; everything upstream of it stops too.
    function automatic logic [5:0] stall_decode(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem)      return 6'b011111;
        else if (req_ex)  return 6'b001111;
        else if (req_id)  return 6'b000111;
        else if (req_if)  return 6'b000011;
        else              return 6'b000000;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - stall-cycle and redirect counters (used under PIPE_PERF_EN)
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    input  logic        redirect,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
);

    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (stall_pc == STOP)
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect)
                redirect_count <= redirect_count + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/redirect controller; PIPE_PERF_EN adds perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stallreq_if,
    input  logic                     stallreq_id,
    input  logic                     stallreq_ex,
    input  logic                     stallreq_mem,
    input  logic                     branch_flag,
    input  logic [INST_ADDR_BUS-1:0] branch_target,
    output logic [5:0]               stall,
    output logic                     redirect_valid,
    output logic [INST_ADDR_BUS-1:0] redirect_addr,
`ifdef PIPE_PERF_EN
    output logic [31:0]              stall_cycles,
    output logic [31:0]              redirect_count,
`endif
    output logic                     flush_if
);

    pipe_state_t              state, state_next;
    logic [INST_ADDR_BUS-1:0] pend_addr, pend_next;
    logic [5:0]               stall_dec;

    assign stall_dec = stall_decode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= PIPE_RUN;
            pend_addr <= ZERO_WORD;
        end else begin
            state     <= state_next;
            pend_addr <= pend_next;
        end
    end

    always_comb begin
        state_next     = state;
        pend_next      = pend_addr;
        stall          = stall_dec;
        redirect_valid = 1'b0;
        redirect_addr  = pend_addr;
        flush_if       = 1'b0;
        if (rst == RST_ENABLE) begin
            stall         = 6'b000000;
            redirect_addr = ZERO_WORD;
        end else begin
            case (state)
                PIPE_RUN: begin
                    // A branch seen while ID is stopped is re-presented later by ID.
                    if (branch_flag && stall_dec[2] == NO_STOP) begin
                        if (stall_dec[1] == NO_STOP) begin
                            redirect_valid = 1'b1;
                            redirect_addr  = branch_target;
                            flush_if       = 1'b1;
                        end else begin
                            pend_next  = branch_target;
                            state_next = PIPE_WAIT;
                        end
                    end
                end
                PIPE_WAIT: begin
                    if (stall_dec[1] == NO_STOP) begin
                        redirect_valid = 1'b1;
                        redirect_addr  = pend_addr;
                        flush_if       = 1'b1;
                        state_next     = PIPE_RUN;
                    end
                end
                default: state_next = PIPE_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] sc_q, rc_q;

    pipe_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_pc       (stall[0]),
        .redirect       (redirect_valid),
        .stall_cycles   (sc_q),
        .redirect_count (rc_q)
    );

    assign stall_cycles   = (rst == RST_ENABLE) ? 32'd0 : sc_q;
    assign redirect_count = (rst == RST_ENABLE) ? 32'd0 : rc_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl; counters checked under PIPE_PERF_EN
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct packed {
        logic [5:0]  stall;
        logic        rv;
        logic [31:0] addr;
        logic        fi;
        logic [31:0] sc;
        logic [31:0] rc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, branch_flag;
    logic [31:0] branch_target;
    logic [5:0]  stall;
    logic        redirect_valid, flush_if;
    logic [31:0] redirect_addr;
    logic [31:0] stall_cycles, redirect_count;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          m_sc = 0;
    int          m_rc = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
`ifdef PIPE_PERF_EN
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count),
`endif
        .flush_if       (flush_if)
    );

`ifndef PIPE_PERF_EN
    assign stall_cycles   = '0;
    assign redirect_count = '0;
`endif

    // Drive one cycle of inputs and queue the hand-computed response; the
    // counter model tracks what the perf counters should read this cycle.
    task automatic step(input logic r, input logic [3:0] req, input logic br,
                        input logic [31:0] tgt, input logic [5:0] e_stall,
                        input logic e_rv, input logic [31:0] e_addr);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        stallreq_mem  = req[3];
        stallreq_ex   = req[2];
        stallreq_id   = req[1];
        stallreq_if   = req[0];
        branch_flag   = br;
        branch_target = tgt;
        e.stall = e_stall;
        e.rv    = e_rv;
        e.addr  = e_addr;
        e.fi    = e_rv;
        e.sc    = r ? 32'd0 : 32'(m_sc);
        e.rc    = r ? 32'd0 : 32'(m_rc);
        sb.push_back(e);
        if (r) begin
            m_sc = 0;
            m_rc = 0;
        end else begin
            if (e_stall[0]) m_sc++;
            if (e_rv)       m_rc++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", {26'd0, stall}, {26'd0, e.stall});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
            chk("redirect_addr", redirect_addr, e.addr);
            chk("flush_if", {31'd0, flush_if}, {31'd0, e.fi});
`ifdef PIPE_PERF_EN
            chk("stall_cycles", stall_cycles, e.sc);
            chk("redirect_count", redirect_count, e.rc);
`endif
            assert (!(rst == 1'b0 && dut.state == PIPE_WAIT && branch_flag))
                else $error("branch_flag asserted while waiting on a held redirect");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d pending, required 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        branch_flag = 0; branch_target = '0;
        //     rst  {mem,ex,id,if} br  target        stall      rv  addr
        step(1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
        step(1'b1, 4'b1000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'b1000, 1'b0, 32'h0,   6'b011111, 1'b0, 32'h0);
        step(1'b0, 4'b0010, 1'b0, 32'h0,   6'b000111, 1'b0, 32'h0);
        step(1'b0, 4'b0110, 1'b0, 32'h0,   6'b001111, 1'b0, 32'h0);
        step(1'b0, 4'b0001, 1'b0, 32'h0,   6'b000011, 1'b0, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'b0000, 1'b1, 32'h100, 6'b000000, 1'b1, 32'h100);
        step(1'b0, 4'b0000, 1'b0, 32'h100, 6'b000000, 1'b0, 32'h0);
        // Branch during an IF stall is held until fetch completes.
        step(1'b0, 4'b0001, 1'b1, 32'h200, 6'b000011, 1'b0, 32'h0);
        step(1'b0, 4'b0001, 1'b0, 32'h0,   6'b000011, 1'b0, 32'h200);
        step(1'b0, 4'b0001, 1'b0, 32'h0,   6'b000011, 1'b0, 32'h200);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h200);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h200);
        // Branches under MEM or ID stall are dropped.
        step(1'b0, 4'b1000, 1'b1, 32'h300, 6'b011111, 1'b0, 32'h200);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h200);
        step(1'b0, 4'b0010, 1'b1, 32'h340, 6'b000111, 1'b0, 32'h200);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h200);
        // Deeper stalls raised while waiting keep the redirect held.
        step(1'b0, 4'b0001, 1'b1, 32'h400, 6'b000011, 1'b0, 32'h200);
        step(1'b0, 4'b1000, 1'b0, 32'h0,   6'b011111, 1'b0, 32'h400);
        step(1'b0, 4'b0100, 1'b0, 32'h0,   6'b001111, 1'b0, 32'h400);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h400);
        // Reset while waiting discards the pending redirect.
        step(1'b0, 4'b0001, 1'b1, 32'h500, 6'b000011, 1'b0, 32'h400);
        step(1'b1, 4'b0001, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'b0000, 1'b1, 32'h600, 6'b000000, 1'b1, 32'h600);
        step(1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller: collects stall requests from the IF, ID, EX and MEM stages and drives the 6-bit `stall` vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb). It also sequences branch redirects resolved in ID. A redirect that arrives while the fetch unit is blocked on memory is held in a register. It is released to pc_reg, together with an IF flush, once the fetch completes.

## Interface
Parameters: none. Widths come from `define.v`: `RegBus` is 32 bits and `InstAddrBus` is 32 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1). Sampled on the `clk` rising edge.
- `stallreq_if`  in  1  fetch is waiting on instruction memory.
- `stallreq_id`  in  1  load-use hazard in ID.
- `stallreq_ex`  in  1  multi-cycle EX operation in progress.
- `stallreq_mem`  in  1  data memory is busy.
- `branch_flag`  in  1  ID has resolved a taken branch or jump.
- `branch_target`  in  `InstAddrBus`  target of that branch.
- `stall`  out  6  per-stage stop bits, `Stop` = 1: bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `redirect_valid`  out  1  pc_reg loads `redirect_addr` on this edge.
- `redirect_addr`  out  `InstAddrBus`  new PC.
- `flush_if`  out  1  if_id discards its captured instruction and loads a NOP.
- `stall_cycles`  out  32  present only under `PIPE_PERF_EN`.
- `redirect_count`  out  32  present only under `PIPE_PERF_EN`.

## Operation
Stall decode is combinational from the requests. The deepest requesting stage wins:
- `stallreq_mem` -> 6'b011111
- else `stallreq_ex` -> 6'b001111
- else `stallreq_id` -> 6'b000111
- else `stallreq_if` -> 6'b000011
- else 6'b000000

Downstream registers insert a bubble where bit k = `Stop` and bit k+1 = `NoStop`.

The controller has a two-state FSM, `RUN` and `WAIT`.

RUN:
- `branch_flag` && `stall[2]` = 0 && `stall[1]` = 0:
  - drive `redirect_valid` = 1, `redirect_addr` = `branch_target` and `flush_if` = 1 combinationally;
  - stay in RUN.
- `branch_flag` && `stall[2]` = 0 && `stall[1]` = 1 (only possible from `stallreq_if`):
  - latch `branch_target` into `pend_addr`;
  - go to WAIT;
  - no redirect output this cycle.
- `branch_flag` && `stall[2]` = 1: ignore the branch. ID will re-present it after the stall clears.

WAIT:
- `stall[1]` = 0:
  - drive `redirect_valid` = 1, `redirect_addr` = `pend_addr` and `flush_if` = 1;
  - return to RUN.
- `stall[1]` = 1: hold in WAIT. This covers `stallreq_if`, and also a MEM or EX stall raised while waiting.
- `branch_flag` in WAIT is illegal, because ID holds a bubble. The RTL ignores it and the bench asserts that it never occurs.

In all other cases: `redirect_valid` = 0, `flush_if` = 0, and `redirect_addr` = the registered `pend_addr`.

## Timing
- Reset (synchronous, on the edge where `rst` = 1):
  - FSM goes to RUN;
  - `pend_addr` = `ZeroWord`;
  - counters = 0.
- While `rst` = 1, all outputs are forced to 0 combinationally, so `stall` = 6'b000000. Reset mid-WAIT discards the pending redirect.
- `stall`: zero latency from the requests.
- Direct redirect: zero latency; pc_reg captures it on the same edge.
- Held redirect: issued in the first cycle with `stall[1]` = 0 after entering WAIT, i.e. at least 1 cycle after the branch.
- `flush_if` is coincident with `redirect_valid`, and is a single-cycle pulse per redirect.
- Simultaneous `stallreq_mem` and `branch_flag`: `stall` = 6'b011111 and the branch is ignored.

## Configuration
`PIPE_PERF_EN` defined: the perf counters and their ports are present.
- `stall_cycles` increments on every cycle with `stall[0]` = 1.
- `redirect_count` increments on every `redirect_valid` = 1.
- Both counters wrap from 0xFFFFFFFF to 0.
- Both clear on `rst`.

`PIPE_PERF_EN` undefined: the ports are absent and the counter logic is not instantiated.

## Structure
- `Stop`/`NoStop`, `RstEnable`, `ZeroWord`, `InstAddrBus` and the FSM state encodings `PIPE_RUN`/`PIPE_WAIT` belong in `define.v`.
- Sub-module `pipe_perf_cnt` holds the two counters, instantiated under `PIPE_PERF_EN`.

## Test plan
- Requests, one at a time: `stallreq_mem` -> `stall` = 6'b011111; `stallreq_id` -> 6'b000111.
- Priority: `stallreq_id` and `stallreq_ex` together -> 6'b001111.
- `branch_flag` = 1, `branch_target` = 0x0000_0100, no stalls:
  - same cycle: `redirect_valid` = 1, `redirect_addr` = 0x100, `flush_if` = 1;
  - next cycle: both are 0.
- `stallreq_if` held for 3 cycles with a branch to 0x200 in the first of them:
  - no redirect while `stallreq_if` is high;
  - in the cycle after it drops: `redirect_valid` = 1, `redirect_addr` = 0x200, `flush_if` = 1.
- Branch ignored under stall: `branch_flag` together with `stallreq_mem` -> `redirect_valid` = 0 and the FSM stays in RUN.
- Reset in WAIT: `rst` during WAIT -> next cycle RUN, `redirect_valid` = 0, `redirect_addr` = 0. With `PIPE_PERF_EN`, both counters read 0.
